// File: rtl/uart_pkg.sv
// Shared definitions for the UART serial path: FSM state encoding and line defaults.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_LOAD  = 3'd2,
    ST_START = 3'd3,
    ST_DATA  = 3'd4,
    ST_STOP  = 3'd5
  } uart_state_e;

  localparam int   CLOCKS_PER_BIT_115200 = 434;
  localparam logic IDLE_LEVEL            = 1'b1;

endpackage

// File: rtl/uart_baud_counter.sv
// Bit-period timer: free-runs while restart is low and pulses bit_end on the
// last cycle of every CLOCKS_PER_BIT-cycle bit period.
module uart_baud_counter #(
  parameter int CLOCKS_PER_BIT = uart_pkg::CLOCKS_PER_BIT_115200
) (
  input  logic CLOCK_50,
  input  logic RST,
  input  logic restart,
  output logic bit_end
);

  localparam int            CW   = $clog2(CLOCKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLOCKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (restart) begin
      cnt_d = '0;
    end else if (cnt_q == LAST) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge CLOCK_50 or posedge RST) begin
    if (RST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bit_end = !restart && (cnt_q == LAST);

endmodule

// File: rtl/fifo_uart_tx.sv
// Pops bytes from the upstream fifo and sends each as a start/data(LSB first)/stop
// frame on tx. All outputs come straight from flops.
module fifo_uart_tx
  import uart_pkg::*;
#(
  parameter int ITEM_SIZE_BITS = 8,
  parameter int CLOCKS_PER_BIT = CLOCKS_PER_BIT_115200,
  parameter int STOP_BITS      = 1
) (
  input  logic                      CLOCK_50,
  input  logic                      RST,
  input  logic                      enable,
  input  logic                      fifo_empty,
  input  logic [ITEM_SIZE_BITS-1:0] fifo_data,
  output logic                      fifo_read,
  output logic                      tx,
  output logic                      busy
);

  localparam int            BW        = $clog2(ITEM_SIZE_BITS + 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(ITEM_SIZE_BITS - 1);
  localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

  uart_state_e               state_q, state_d;
  logic [ITEM_SIZE_BITS-1:0] shift_q, shift_d;
  logic [ITEM_SIZE_BITS-1:0] shift_next_s;
  logic [BW-1:0]             bit_cnt_q, bit_cnt_d;
  logic                      tx_q, tx_d;
  logic                      fifo_read_q, fifo_read_d;
  logic                      busy_q, busy_d;
  logic                      restart_s;
  logic                      bit_end_s;

  // Counter is held at zero outside the line states so START always gets a full bit.
  assign restart_s = !((state_q == ST_START) || (state_q == ST_DATA) || (state_q == ST_STOP));

  uart_baud_counter #(
    .CLOCKS_PER_BIT(CLOCKS_PER_BIT)
  ) u_baud (
    .CLOCK_50(CLOCK_50),
    .RST     (RST),
    .restart (restart_s),
    .bit_end (bit_end_s)
  );

  assign shift_next_s = shift_q >> 1;

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    tx_d        = tx_q;
    fifo_read_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (enable && !fifo_empty) begin
          fifo_read_d = 1'b1;
          state_d     = ST_REQ;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_REQ: begin
        state_d = ST_LOAD;
      end
      ST_LOAD: begin
        shift_d = fifo_data;
        tx_d    = 1'b0;
        state_d = ST_START;
      end
      ST_START: begin
        if (bit_end_s) begin
          tx_d      = shift_q[0];
          bit_cnt_d = '0;
          state_d   = ST_DATA;
        end else begin
          state_d = ST_START;
        end
      end
      ST_DATA: begin
        if (bit_end_s) begin
          shift_d = shift_next_s;
          if (bit_cnt_q == LAST_BIT) begin
            tx_d      = IDLE_LEVEL;
            bit_cnt_d = '0;
            state_d   = ST_STOP;
          end else begin
            tx_d      = shift_next_s[0];
            bit_cnt_d = bit_cnt_q + BW'(1);
          end
        end else begin
          state_d = ST_DATA;
        end
      end
      ST_STOP: begin
        // The bit counter is reused to count stop-bit periods.
        if (bit_end_s) begin
          if (bit_cnt_q == LAST_STOP) begin
            bit_cnt_d = '0;
            state_d   = ST_IDLE;
          end else begin
            bit_cnt_d = bit_cnt_q + BW'(1);
          end
        end else begin
          state_d = ST_STOP;
        end
      end
      default: begin
        tx_d      = IDLE_LEVEL;
        bit_cnt_d = '0;
        state_d   = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge CLOCK_50 or posedge RST) begin
    if (RST) begin
      state_q     <= ST_IDLE;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      tx_q        <= IDLE_LEVEL;
      fifo_read_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      tx_q        <= tx_d;
      fifo_read_q <= fifo_read_d;
      busy_q      <= busy_d;
    end
  end

  assign tx        = tx_q;
  assign fifo_read = fifo_read_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx: one instance with 1 stop bit, one with 2,
// both at 4 clocks per bit, each fed by a small registered-output fifo model.
module tb_fifo_uart_tx;

  localparam int CPB = 4;

  logic       CLOCK_50 = 1'b0;
  logic       RST      = 1'b1;
  logic       enable1  = 1'b0;
  logic       enable2  = 1'b0;
  logic [7:0] fifo_data1 = 8'h00;
  logic [7:0] fifo_data2 = 8'h00;
  logic       fifo_empty1, fifo_empty2;
  logic       fifo_read1, fifo_read2;
  logic       tx1, tx2, busy1, busy2;

  logic [7:0] q1[$];
  logic [7:0] q2[$];

  int n_cmp = 0;
  int n_bad = 0;
  int rd_cnt1 = 0, rd_cnt2 = 0, busy_cnt1 = 0, busy_cnt2 = 0, rd_while_empty = 0;

  fifo_uart_tx #(.ITEM_SIZE_BITS(8), .CLOCKS_PER_BIT(CPB), .STOP_BITS(1)) u_dut1 (
    .CLOCK_50(CLOCK_50), .RST(RST), .enable(enable1), .fifo_empty(fifo_empty1),
    .fifo_data(fifo_data1), .fifo_read(fifo_read1), .tx(tx1), .busy(busy1)
  );

  fifo_uart_tx #(.ITEM_SIZE_BITS(8), .CLOCKS_PER_BIT(CPB), .STOP_BITS(2)) u_dut2 (
    .CLOCK_50(CLOCK_50), .RST(RST), .enable(enable2), .fifo_empty(fifo_empty2),
    .fifo_data(fifo_data2), .fifo_read(fifo_read2), .tx(tx2), .busy(busy2)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  assign fifo_empty1 = (q1.size() == 0);
  assign fifo_empty2 = (q2.size() == 0);

  // Fifo model: data_out is registered and updates on the edge that accepts a read.
  always @(posedge CLOCK_50) begin
    if (fifo_read1 && q1.size() != 0) fifo_data1 <= q1.pop_front();
    if (fifo_read2 && q2.size() != 0) fifo_data2 <= q2.pop_front();
  end

  always @(negedge CLOCK_50) begin
    if (fifo_read1) rd_cnt1++;
    if (fifo_read2) rd_cnt2++;
    if (busy1) busy_cnt1++;
    if (busy2) busy_cnt2++;
    if ((fifo_read1 && fifo_empty1) || (fifo_read2 && fifo_empty2)) rd_while_empty++;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  function automatic logic sel_tx(input int sel);
    return (sel == 1) ? tx1 : tx2;
  endfunction

  // Edges until tx is seen low; -1 if it never falls within the bound.
  task automatic wait_low(input int sel, input int max_edges, output int edges);
    bit found;
    found = 1'b0;
    edges = -1;
    for (int i = 1; i <= max_edges && !found; i++) begin
      tick();
      if (sel_tx(sel) == 1'b0) begin
        edges = i;
        found = 1'b1;
      end
    end
  endtask

  // One tx sample per cycle, starting with the current one.
  task automatic collect(input int sel, input int n, output logic [63:0] v);
    v = '0;
    for (int k = 0; k < n; k++) begin
      if (k > 0) tick();
      v[k] = sel_tx(sel);
    end
  endtask

  function automatic logic [63:0] frame_vec(input logic [7:0] b, input int stops);
    logic [63:0] v;
    logic        lvl;
    v = '0;
    for (int l = 0; l < 9 + stops; l++) begin
      if (l == 0) lvl = 1'b0;
      else if (l <= 8) lvl = b[l-1];
      else lvl = 1'b1;
      for (int j = 0; j < CPB; j++) v[l*CPB + j] = lvl;
    end
    return v;
  endfunction

  initial begin
    int          lat, gap, lows, rd_base, busy_base;
    logic [63:0] v;

    repeat (3) @(posedge CLOCK_50);
    #1;
    check_eq("reset_tx", 64'(tx1), 64'h1);
    check_eq("reset_busy", 64'(busy1), 64'h0);
    check_eq("reset_read", 64'(fifo_read1), 64'h0);
    RST = 1'b0;
    tick();

    // Single byte 0xA5
    enable1   = 1'b1;
    rd_base   = rd_cnt1;
    busy_base = busy_cnt1;
    q1.push_back(8'hA5);
    wait_low(1, 20, lat);
    check_eq("a5_latency", 64'(lat), 64'd3);
    collect(1, 40, v);
    check_eq("a5_frame", v, frame_vec(8'hA5, 1));
    repeat (10) tick();
    // REQ + LOAD + start + 8 data + 1 stop = 1+1+4+32+4
    check_eq("a5_busy_cycles", 64'(busy_cnt1 - busy_base), 64'd42);
    check_eq("a5_reads", 64'(rd_cnt1 - rd_base), 64'd1);

    // Back-to-back 0x55, 0x0F
    rd_base = rd_cnt1;
    q1.push_back(8'h55);
    q1.push_back(8'h0F);
    wait_low(1, 20, lat);
    check_eq("b2b_latency", 64'(lat), 64'd3);
    collect(1, 40, v);
    check_eq("b2b_frame0", v, frame_vec(8'h55, 1));
    gap = 0;
    begin
      bit done;
      done = 1'b0;
      for (int i = 0; i < 20 && !done; i++) begin
        tick();
        if (tx1) gap++;
        else done = 1'b1;
      end
    end
    check_eq("b2b_gap", 64'(gap), 64'd3);
    collect(1, 40, v);
    check_eq("b2b_frame1", v, frame_vec(8'h0F, 1));
    lows = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (!tx1) lows++;
    end
    check_eq("b2b_reads", 64'(rd_cnt1 - rd_base), 64'd2);
    check_eq("b2b_empty_after", 64'(fifo_empty1), 64'h1);
    check_eq("b2b_idle_lows", 64'(lows), 64'd0);

    // Empty and enable gating
    rd_base = rd_cnt1;
    repeat (100) tick();
    check_eq("empty_no_read", 64'(rd_cnt1 - rd_base), 64'd0);
    enable1 = 1'b0;
    q1.push_back(8'h3C);
    repeat (20) tick();
    check_eq("disabled_no_read", 64'(rd_cnt1 - rd_base), 64'd0);
    check_eq("disabled_tx", 64'(tx1), 64'h1);
    enable1 = 1'b1;
    wait_low(1, 20, lat);
    check_eq("enable_latency", 64'(lat), 64'd3);
    collect(1, 40, v);
    check_eq("enable_frame", v, frame_vec(8'h3C, 1));
    repeat (10) tick();
    check_eq("no_read_while_empty", 64'(rd_while_empty), 64'd0);

    // Asynchronous reset in the middle of DATA
    rd_base = rd_cnt1;
    q1.push_back(8'h81);
    wait_low(1, 20, lat);
    repeat (8) tick();
    check_eq("pre_reset_tx", 64'(tx1), 64'h0);
    #1 RST = 1'b1;
    #1;
    check_eq("async_reset_tx", 64'(tx1), 64'h1);
    check_eq("async_reset_busy", 64'(busy1), 64'h0);
    check_eq("async_reset_read", 64'(fifo_read1), 64'h0);
    tick();
    tick();
    RST = 1'b0;
    lows = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (!tx1) lows++;
    end
    check_eq("post_reset_idle_lows", 64'(lows), 64'd0);
    check_eq("post_reset_busy", 64'(busy1), 64'h0);
    check_eq("post_reset_reads", 64'(rd_cnt1 - rd_base), 64'd1);

    // Two stop bits, enable dropped mid-frame, fifo write during the frame
    enable2   = 1'b1;
    rd_base   = rd_cnt2;
    busy_base = busy_cnt2;
    q2.push_back(8'hFF);
    wait_low(2, 20, lat);
    check_eq("stop2_latency", 64'(lat), 64'd3);
    repeat (12) tick();
    enable2 = 1'b0;
    q2.push_back(8'h00);
    lows = 0;
    for (int i = 0; i < 80; i++) begin
      tick();
      if (!tx2) lows++;
    end
    // REQ + LOAD + start + 8 data + 2 stop = 1+1+4+32+8
    check_eq("stop2_busy_cycles", 64'(busy_cnt2 - busy_base), 64'd46);
    check_eq("stop2_reads_disabled", 64'(rd_cnt2 - rd_base), 64'd1);
    check_eq("stop2_ff_lows", 64'(lows), 64'd0);
    enable2 = 1'b1;
    wait_low(2, 20, lat);
    check_eq("stop2_relatency", 64'(lat), 64'd3);
    collect(2, 44, v);
    check_eq("stop2_frame00", v, frame_vec(8'h00, 2));
    repeat (10) tick();
    check_eq("stop2_total_busy", 64'(busy_cnt2 - busy_base), 64'd92);
    check_eq("stop2_reads_total", 64'(rd_cnt2 - rd_base), 64'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
